// File: rtl/mtm_alu_result_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : mtm_alu_result_receiver_if
// Description : Serial line plus decoded result bundle of the ALU result receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface mtm_alu_result_receiver_if;
    logic        sin;
    logic        r_valid;
    logic [31:0] C;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        negative;
    logic [7:0]  ctl;
    logic        crc_ok;
    logic        err_rsp;
    logic        frame_err;

    // master: serializer / host side that drives the line and consumes results
    modport master (
        output sin,
        input  r_valid, C, carry, overflow, zero, negative, ctl, crc_ok, err_rsp, frame_err
    );

    // slave: the receiver itself
    modport slave (
        input  sin,
        output r_valid, C, carry, overflow, zero, negative, ctl, crc_ok, err_rsp, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/mtm_alu_result_receiver.sv
`default_nettype none
// ============================================================================
// Module      : mtm_alu_result_receiver
// Description : Rebuilds an ALU result packet (4 data + 1 control frame) from
//               the serial line and checks its CRC-3.
// Revision    : 1.0 - initial release
// ============================================================================
module mtm_alu_result_receiver (
    input  logic                         clk,
    input  logic                         rst,
    mtm_alu_result_receiver_if.slave     bus
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_type = 3'd1;
    localparam logic [2:0] c_st_data = 3'd2;
    localparam logic [2:0] c_st_stop = 3'd3;
    localparam logic [2:0] c_st_wait = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  r_data_cnt;
    logic        r_type;
    logic [7:0]  r_shift;
    logic [31:0] r_buf;
    logic [2:0]  r_crc_pkt;
    logic [2:0]  r_crc_run;

    logic        r_valid_out;
    logic [31:0] r_c;
    logic [3:0]  r_flags;
    logic [7:0]  r_ctl;
    logic        r_crc_ok;
    logic        r_err_rsp;
    logic        r_frame_err;

    logic        w_fb;
    logic [2:0]  w_crc_next;
    logic [2:0]  w_crc_seed;

    assign w_fb       = r_crc_run[2] ^ bus.sin;
    assign w_crc_next = {r_crc_run[1], r_crc_run[0] ^ w_fb, w_fb};
    // A data frame arriving with four bytes already held starts a new packet,
    // so its CRC must start from zero rather than continue the old one.
    assign w_crc_seed = ((r_data_cnt == 3'd0) || ((r_data_cnt == 3'd4) && !bus.sin))
                        ? 3'd0 : r_crc_pkt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_bit_cnt   <= 3'd0;
            r_data_cnt  <= 3'd0;
            r_type      <= 1'b0;
            r_shift     <= 8'd0;
            r_buf       <= 32'd0;
            r_crc_pkt   <= 3'd0;
            r_crc_run   <= 3'd0;
            r_valid_out <= 1'b0;
            r_c         <= 32'd0;
            r_flags     <= 4'd0;
            r_ctl       <= 8'd0;
            r_crc_ok    <= 1'b0;
            r_err_rsp   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (!bus.sin) begin
                        r_state <= c_st_type;
                    end
                end
                c_st_type: begin
                    r_type    <= bus.sin;
                    r_bit_cnt <= 3'd0;
                    r_crc_run <= w_crc_seed;
                    r_state   <= c_st_data;
                end
                c_st_data: begin
                    r_shift <= {r_shift[6:0], bus.sin};
                    // Control frames contribute only their top five bits to the CRC.
                    if (!r_type || (r_bit_cnt < 3'd5)) begin
                        r_crc_run <= w_crc_next;
                    end
                    if (r_bit_cnt == 3'd7) begin
                        r_state <= c_st_stop;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                c_st_stop: begin
                    if (bus.sin) begin
                        r_state <= c_st_idle;
                        if (!r_type) begin
                            r_crc_pkt <= r_crc_run;
                            if (r_data_cnt == 3'd4) begin
                                r_frame_err   <= 1'b1;
                                r_buf[31:24]  <= r_shift;
                                r_data_cnt    <= 3'd1;
                            end else begin
                                case (r_data_cnt)
                                    3'd0:    r_buf[31:24] <= r_shift;
                                    3'd1:    r_buf[23:16] <= r_shift;
                                    3'd2:    r_buf[15:8]  <= r_shift;
                                    default: r_buf[7:0]   <= r_shift;
                                endcase
                                r_data_cnt <= r_data_cnt + 3'd1;
                            end
                        end else begin
                            r_data_cnt <= 3'd0;
                            r_crc_pkt  <= 3'd0;
                            if ((r_data_cnt == 3'd4) && !r_shift[7]) begin
                                r_valid_out <= 1'b1;
                                r_c         <= r_buf;
                                r_flags     <= r_shift[6:3];
                                r_ctl       <= r_shift;
                                r_crc_ok    <= (r_crc_run == r_shift[2:0]);
                                r_err_rsp   <= 1'b0;
                            end else if ((r_data_cnt == 3'd0) && r_shift[7]) begin
                                r_valid_out <= 1'b1;
                                r_ctl       <= r_shift;
                                r_err_rsp   <= 1'b1;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end
                    end else begin
                        r_frame_err <= 1'b1;
                        r_data_cnt  <= 3'd0;
                        r_crc_pkt   <= 3'd0;
                        r_state     <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (bus.sin) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.r_valid   = r_valid_out;
    assign bus.C         = r_c;
    assign bus.carry     = r_flags[3];
    assign bus.overflow  = r_flags[2];
    assign bus.zero      = r_flags[1];
    assign bus.negative  = r_flags[0];
    assign bus.ctl       = r_ctl;
    assign bus.crc_ok    = r_crc_ok;
    assign bus.err_rsp   = r_err_rsp;
    assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_result_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_mtm_alu_result_receiver
// Description : Directed and randomized checks of the ALU result receiver
//               against a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mtm_alu_result_receiver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mtm_alu_result_receiver_if bus();

    mtm_alu_result_receiver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // packet-level reference state
    logic [7:0]  pend[$];
    logic [31:0] m_c      = 32'd0;
    logic [3:0]  m_flags  = 4'd0;
    logic [7:0]  m_ctl    = 8'd0;
    logic        m_crc_ok = 1'b0;
    logic        m_err    = 1'b0;
    logic        e_valid  = 1'b0;
    logic        e_ferr   = 1'b0;
    logic        e_rst    = 1'b0;
    int          valid_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [2:0] crc3(input logic [36:0] v);
        int r = 0;
        for (int i = 36; i >= 0; i--) begin
            int fb = ((r >> 2) & 1) ^ int'(v[i]);
            r = ((r << 1) & 7) ^ (fb != 0 ? 3 : 0);
        end
        return r[2:0];
    endfunction

    // One clock: sample what the previous edge produced, then drive the next bit.
    task automatic tick(input logic b, input logic r = 1'b0);
        @(negedge clk);
        cyc++;
        if (e_rst) begin
            check("rst_r_valid",   bus.r_valid,   0);
            check("rst_frame_err", bus.frame_err, 0);
            check("rst_C",         bus.C,         0);
            check("rst_ctl",       bus.ctl,       0);
            check("rst_flags",     {bus.carry, bus.overflow, bus.zero, bus.negative}, 0);
            check("rst_crc_ok",    bus.crc_ok,    0);
            check("rst_err_rsp",   bus.err_rsp,   0);
        end
        if (bus.r_valid || e_valid) begin
            check("r_valid", bus.r_valid, e_valid);
            if (e_valid) begin
                valid_cyc.push_back(cyc);
                check("C",       bus.C,       m_c);
                check("flags",   {bus.carry, bus.overflow, bus.zero, bus.negative}, m_flags);
                check("ctl",     bus.ctl,     m_ctl);
                check("crc_ok",  bus.crc_ok,  m_crc_ok);
                check("err_rsp", bus.err_rsp, m_err);
            end
        end
        if (bus.frame_err || e_ferr) begin
            check("frame_err", bus.frame_err, e_ferr);
        end
        e_valid = 1'b0;
        e_ferr  = 1'b0;
        e_rst   = 1'b0;
        bus.sin = b;
        rst     = r;
        if (r) begin
            pend.delete();
            m_c = 0; m_flags = 0; m_ctl = 0; m_crc_ok = 0; m_err = 0;
            e_rst = 1'b1;
        end
    endtask

    task automatic commit(input logic typ, input logic [7:0] pl, input logic good);
        if (!good) begin
            e_ferr = 1'b1;
            pend.delete();
        end else if (!typ) begin
            if (pend.size() == 4) begin
                e_ferr = 1'b1;
                pend.delete();
            end
            pend.push_back(pl);
        end else begin
            if (pend.size() == 4 && !pl[7]) begin
                m_c      = {pend[0], pend[1], pend[2], pend[3]};
                m_flags  = pl[6:3];
                m_ctl    = pl;
                m_crc_ok = (crc3({m_c, 1'b0, pl[6:3]}) == pl[2:0]);
                m_err    = 1'b0;
                e_valid  = 1'b1;
            end else if (pend.size() == 0 && pl[7]) begin
                m_ctl   = pl;
                m_err   = 1'b1;
                e_valid = 1'b1;
            end else begin
                e_ferr = 1'b1;
            end
            pend.delete();
        end
    endtask

    task automatic send_frame(input logic typ, input logic [7:0] pl, input int gap,
                              input logic good = 1'b1, input int zeros = 0);
        tick(1'b0);
        tick(typ);
        for (int i = 7; i >= 0; i--) tick(pl[i]);
        tick(good);
        commit(typ, pl, good);
        if (!good) begin
            for (int i = 0; i < zeros; i++) tick(1'b0);
            tick(1'b1);
        end
        for (int i = 0; i < gap; i++) tick(1'b1);
    endtask

    task automatic send_packet(input logic [31:0] c, input logic [3:0] fl,
                               input logic [2:0] corrupt, input int gap);
        logic [7:0] cb;
        for (int i = 3; i >= 0; i--) begin
            cb = c[i*8 +: 8];
            send_frame(1'b0, cb, gap < 0 ? int'($urandom_range(0, 2)) : gap);
        end
        send_frame(1'b1, {1'b0, fl, crc3({c, 1'b0, fl}) ^ corrupt},
                   gap < 0 ? int'($urandom_range(0, 2)) : gap);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind;
        int n;
        logic [7:0] rb;
        bus.sin = 1'b1;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1);
        tick(1'b1);

        // nominal, corrupted crc, error response
        send_packet(32'h12345678, 4'b0000, 3'b000, 1);
        send_packet(32'h12345678, 4'b0000, 3'b001, 1);
        send_frame(1'b1, 8'hC9, 1);

        // stop-bit violation on data frame 2, then a good packet
        send_frame(1'b0, 8'hAA, 1);
        send_frame(1'b0, 8'hBB, 0, 1'b0, 2);
        send_packet(32'hDEADBEEF, 4'b0101, 3'b000, 1);

        // sequence error then bare error response
        for (int i = 0; i < 3; i++) send_frame(1'b0, 8'h11 * (i + 1), 1);
        send_frame(1'b1, 8'h00, 1);
        send_frame(1'b1, 8'h80, 1);

        // back-to-back packets, zero idle bits
        valid_cyc.delete();
        send_packet(32'hFFFFFFFF, 4'b1001, 3'b000, 0);
        send_packet(32'h00000000, 4'b0010, 3'b000, 0);
        tick(1'b1);
        check("b2b_count", valid_cyc.size(), 2);
        if (valid_cyc.size() >= 2) check("b2b_spacing", valid_cyc[1] - valid_cyc[0], 55);

        // reset in the middle of a third packet
        send_frame(1'b0, 8'h5A, 0);
        send_frame(1'b0, 8'hA5, 0);
        tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0);
        tick(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) tick(1'b1);
        send_packet(32'hCAFEF00D, 4'b0110, 3'b000, 1);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                send_packet($urandom, 4'($urandom),
                            ($urandom_range(0, 3) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000, -1);
            end else if (kind == 6) begin
                rb = 8'($urandom);
                send_frame(1'b1, {1'b1, rb[6:0]}, $urandom_range(0, 2));
            end else if (kind == 7) begin
                send_frame(1'b0, 8'($urandom), 0, 1'b0, $urandom_range(0, 3));
            end else begin
                n = $urandom_range(0, 5);
                for (int i = 0; i < n; i++) send_frame(1'b0, 8'($urandom), $urandom_range(0, 1));
                send_frame(1'b1, 8'($urandom), $urandom_range(0, 2));
            end
        end
        for (int i = 0; i < 4; i++) tick(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
